// File: rtl/forward_wb_history_if.sv
// Bundle of the WB writeback, consumer operand and forwarding result signals
// shared between the pipeline and the writeback history bypass.
interface forward_wb_history_if #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int NPORTS = 2,
  parameter int CNT_W  = 3
);
  logic                    wb_load_regfile;
  logic [REG_W-1:0]        wb_rd_num;
  logic [XLEN-1:0]         wb_rd_data;
  logic                    flush;
  logic [NPORTS-1:0]       use_fwd;
  logic [NPORTS*REG_W-1:0] src_num;
  logic [NPORTS*XLEN-1:0]  src_data;
  logic [NPORTS*XLEN-1:0]  fwd_data;
  logic [NPORTS-1:0]       fwd_hit;
  logic [NPORTS*CNT_W-1:0] fwd_src;
  logic [CNT_W-1:0]        hist_count;

  modport master (
    output wb_load_regfile, wb_rd_num, wb_rd_data, flush, use_fwd, src_num, src_data,
    input  fwd_data, fwd_hit, fwd_src, hist_count
  );

  modport slave (
    input  wb_load_regfile, wb_rd_num, wb_rd_data, flush, use_fwd, src_num, src_data,
    output fwd_data, fwd_hit, fwd_src, hist_count
  );
endinterface

// File: rtl/forward_wb_history.sv
// Writeback history bypass: remembers the last DEPTH regfile writes so stalled
// consumers still see a producer's result after it has retired from WB.
module forward_wb_history #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4,
  parameter int NPORTS = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  forward_wb_history_if.slave bus
);

  logic [DEPTH-1:0]        r_valid;
  logic [REG_W-1:0]        r_rd   [DEPTH];
  logic [XLEN-1:0]         r_data [DEPTH];
  logic [CNT_W-1:0]        r_count;

  logic                    w_push;
  logic [DEPTH-1:0]        w_valid_nxt;
  logic [REG_W-1:0]        w_rd_nxt   [DEPTH];
  logic [XLEN-1:0]         w_data_nxt [DEPTH];

  logic [REG_W-1:0]        w_num   [NPORTS];
  logic [DEPTH-1:0]        w_match [NPORTS];
  logic [CNT_W-1:0]        w_hsel  [NPORTS];
  logic [XLEN-1:0]         w_hdata [NPORTS];
  logic [NPORTS*XLEN-1:0]  w_fwd_data;
  logic [NPORTS-1:0]       w_fwd_hit;
  logic [NPORTS*CNT_W-1:0] w_fwd_src;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  assign w_push = bus.wb_load_regfile && (bus.wb_rd_num != '0);

  // Next history contents: shift-in on push with same-rd de-duplication, flush drops older entries.
  always_comb begin
    w_valid_nxt = r_valid;
    w_rd_nxt    = r_rd;
    w_data_nxt  = r_data;
    if (w_push) begin
      w_valid_nxt[0] = 1'b1;
      w_rd_nxt[0]    = bus.wb_rd_num;
      w_data_nxt[0]  = bus.wb_rd_data;
      for (int i = 1; i < DEPTH; i++) begin
        w_valid_nxt[i] = r_valid[i-1] && (r_rd[i-1] != bus.wb_rd_num) && !bus.flush;
        w_rd_nxt[i]    = r_rd[i-1];
        w_data_nxt[i]  = r_data[i-1];
      end
    end else if (bus.flush) begin
      w_valid_nxt = '0;
    end else begin
      w_valid_nxt = r_valid;
    end
  end

  // History state and its registered occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_count <= popcount(w_valid_nxt);
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= w_rd_nxt[i];
        r_data[i] <= w_data_nxt[i];
      end
    end
  end

  // Per-port lookup: live WB beats history, and the lowest (newest) history index wins.
  always_comb begin
    w_fwd_data = bus.src_data;
    w_fwd_hit  = '0;
    w_fwd_src  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_num[p]   = bus.src_num[p*REG_W +: REG_W];
      w_match[p] = '0;
      w_hsel[p]  = '0;
      w_hdata[p] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        w_match[p][k] = r_valid[k] && (r_rd[k] == w_num[p]);
        w_hsel[p]     = w_match[p][k] ? CNT_W'(k + 1) : w_hsel[p];
        w_hdata[p]    = w_match[p][k] ? r_data[k] : w_hdata[p];
      end
      if (!bus.use_fwd[p] || (w_num[p] == '0)) begin
        w_fwd_hit[p] = 1'b0;
      end else if (bus.wb_load_regfile && (bus.wb_rd_num == w_num[p])) begin
        w_fwd_data[p*XLEN +: XLEN]   = bus.wb_rd_data;
        w_fwd_hit[p]                 = 1'b1;
        w_fwd_src[p*CNT_W +: CNT_W]  = '0;
      end else if (w_hsel[p] != '0) begin
        w_fwd_data[p*XLEN +: XLEN]   = w_hdata[p];
        w_fwd_hit[p]                 = 1'b1;
        w_fwd_src[p*CNT_W +: CNT_W]  = w_hsel[p];
      end else begin
        w_fwd_hit[p] = 1'b0;
      end
    end
  end

  assign bus.fwd_data   = w_fwd_data;
  assign bus.fwd_hit    = w_fwd_hit;
  assign bus.fwd_src    = w_fwd_src;
  assign bus.hist_count = r_count;

endmodule

// File: tb/tb_forward_wb_history.sv
// Table-driven bench for the writeback history bypass with a queue of expected
// results, plus a hand-written asynchronous-reset sequence.
module tb_forward_wb_history;
  localparam int XLEN   = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 4;
  localparam int NPORTS = 2;
  localparam int CNT_W  = 3;
  localparam logic [31:0] P0 = 32'hDEAD_0000;
  localparam logic [31:0] P1 = 32'hBEEF_0001;

  typedef struct {
    logic        wl;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        fl;
    logic [1:0]  en;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic        h0;
    logic [2:0]  c0;
    logic [31:0] d0;
    logic        h1;
    logic [2:0]  c1;
    logic [31:0] d1;
    logic [2:0]  cnt;
  } vec_t;

  typedef struct {
    logic        h0;
    logic [2:0]  c0;
    logic [31:0] d0;
    logic        h1;
    logic [2:0]  c1;
    logic [31:0] d1;
    logic [2:0]  cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  vec_t tbl [23];
  exp_t exp_q [$];

  forward_wb_history_if #(.XLEN(XLEN), .REG_W(REG_W), .NPORTS(NPORTS), .CNT_W(CNT_W)) bus ();

  forward_wb_history #(
    .XLEN(XLEN), .REG_W(REG_W), .DEPTH(DEPTH), .NPORTS(NPORTS), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic wl, input logic [4:0] rd, input logic [31:0] wd,
                              input logic fl, input logic [1:0] en,
                              input logic [4:0] s0, input logic [4:0] s1,
                              input logic h0, input logic [2:0] c0, input logic [31:0] d0,
                              input logic h1, input logic [2:0] c1, input logic [31:0] d1,
                              input logic [2:0] cnt);
    vec_t v;
    v.wl = wl; v.rd = rd; v.wd = wd; v.fl = fl; v.en = en; v.s0 = s0; v.s1 = s1;
    v.h0 = h0; v.c0 = c0; v.d0 = d0; v.h1 = h1; v.c1 = c1; v.d1 = d1; v.cnt = cnt;
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.h0 = v.h0; e.c0 = v.c0; e.d0 = v.d0; e.h1 = v.h1; e.c1 = v.c1; e.d1 = v.d1; e.cnt = v.cnt;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    bus.wb_load_regfile = v.wl;
    bus.wb_rd_num       = v.rd;
    bus.wb_rd_data      = v.wd;
    bus.flush           = v.fl;
    bus.use_fwd         = v.en;
    bus.src_num         = {v.s1, v.s0};
    bus.src_data        = {P1, P0};
  endtask

  task automatic cmp(input string nm, input int tag, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=0x%08h expected=0x%08h", nm, tag, got, want);
    end
  endtask

  task automatic check_out(input int tag);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty vec=%0d got=0 entries expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      cmp("hit0",  tag, 32'(bus.fwd_hit[0]),     32'(e.h0));
      cmp("src0",  tag, 32'(bus.fwd_src[2:0]),   32'(e.c0));
      cmp("data0", tag, bus.fwd_data[31:0],      e.d0);
      cmp("hit1",  tag, 32'(bus.fwd_hit[1]),     32'(e.h1));
      cmp("src1",  tag, 32'(bus.fwd_src[5:3]),   32'(e.c1));
      cmp("data1", tag, bus.fwd_data[63:32],     e.d1);
      cmp("count", tag, 32'(bus.hist_count),     32'(e.cnt));
    end
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_bad = 0;
    tbl[0]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 2'b11, 5'd5, 5'd5, 1'b0, 3'd0, P0,       1'b0, 3'd0, P1,       3'd0);
    tbl[1]  = mk(1'b1, 5'd5, 32'h11,   1'b0, 2'b11, 5'd5, 5'd0, 1'b1, 3'd0, 32'h11,   1'b0, 3'd0, P1,       3'd0);
    tbl[2]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 2'b11, 5'd5, 5'd5, 1'b1, 3'd1, 32'h11,   1'b1, 3'd1, 32'h11,   3'd1);
    tbl[3]  = mk(1'b1, 5'd1, 32'hA1,   1'b0, 2'b11, 5'd1, 5'd5, 1'b1, 3'd0, 32'hA1,   1'b1, 3'd1, 32'h11,   3'd1);
    tbl[4]  = mk(1'b1, 5'd2, 32'hA2,   1'b0, 2'b11, 5'd5, 5'd1, 1'b1, 3'd2, 32'h11,   1'b1, 3'd1, 32'hA1,   3'd2);
    tbl[5]  = mk(1'b1, 5'd3, 32'hA3,   1'b0, 2'b11, 5'd2, 5'd5, 1'b1, 3'd1, 32'hA2,   1'b1, 3'd3, 32'h11,   3'd3);
    tbl[6]  = mk(1'b1, 5'd4, 32'hA4,   1'b0, 2'b11, 5'd1, 5'd3, 1'b1, 3'd3, 32'hA1,   1'b1, 3'd1, 32'hA3,   3'd4);
    tbl[7]  = mk(1'b1, 5'd5, 32'hA5,   1'b0, 2'b11, 5'd5, 5'd5, 1'b1, 3'd0, 32'hA5,   1'b1, 3'd0, 32'hA5,   3'd4);
    tbl[8]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 2'b11, 5'd1, 5'd5, 1'b0, 3'd0, P0,       1'b1, 3'd1, 32'hA5,   3'd4);
    tbl[9]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 2'b11, 5'd2, 5'd4, 1'b1, 3'd4, 32'hA2,   1'b1, 3'd2, 32'hA4,   3'd4);
    tbl[10] = mk(1'b0, 5'd0, 32'h0,    1'b1, 2'b11, 5'd2, 5'd0, 1'b1, 3'd4, 32'hA2,   1'b0, 3'd0, P1,       3'd4);
    tbl[11] = mk(1'b1, 5'd3, 32'h10,   1'b0, 2'b11, 5'd2, 5'd3, 1'b0, 3'd0, P0,       1'b1, 3'd0, 32'h10,   3'd0);
    tbl[12] = mk(1'b1, 5'd7, 32'h20,   1'b0, 2'b11, 5'd3, 5'd7, 1'b1, 3'd1, 32'h10,   1'b1, 3'd0, 32'h20,   3'd1);
    tbl[13] = mk(1'b1, 5'd3, 32'h30,   1'b0, 2'b11, 5'd3, 5'd7, 1'b1, 3'd0, 32'h30,   1'b1, 3'd1, 32'h20,   3'd2);
    tbl[14] = mk(1'b0, 5'd0, 32'h0,    1'b0, 2'b11, 5'd3, 5'd7, 1'b1, 3'd1, 32'h30,   1'b1, 3'd2, 32'h20,   3'd2);
    tbl[15] = mk(1'b1, 5'd3, 32'h40,   1'b0, 2'b01, 5'd3, 5'd3, 1'b1, 3'd0, 32'h40,   1'b0, 3'd0, P1,       3'd2);
    tbl[16] = mk(1'b1, 5'd0, 32'hFFFF, 1'b0, 2'b11, 5'd0, 5'd7, 1'b0, 3'd0, P0,       1'b1, 3'd3, 32'h20,   3'd2);
    tbl[17] = mk(1'b0, 5'd0, 32'h0,    1'b0, 2'b11, 5'd3, 5'd7, 1'b1, 3'd1, 32'h40,   1'b1, 3'd3, 32'h20,   3'd2);
    tbl[18] = mk(1'b1, 5'd8, 32'h88,   1'b0, 2'b11, 5'd8, 5'd0, 1'b1, 3'd0, 32'h88,   1'b0, 3'd0, P1,       3'd2);
    tbl[19] = mk(1'b1, 5'd9, 32'h99,   1'b1, 2'b11, 5'd3, 5'd9, 1'b1, 3'd2, 32'h40,   1'b1, 3'd0, 32'h99,   3'd3);
    tbl[20] = mk(1'b0, 5'd0, 32'h0,    1'b0, 2'b11, 5'd3, 5'd9, 1'b0, 3'd0, P0,       1'b1, 3'd1, 32'h99,   3'd1);
    tbl[21] = mk(1'b0, 5'd0, 32'h0,    1'b1, 2'b11, 5'd9, 5'd7, 1'b1, 3'd1, 32'h99,   1'b0, 3'd0, P1,       3'd1);
    tbl[22] = mk(1'b0, 5'd0, 32'h0,    1'b0, 2'b11, 5'd9, 5'd9, 1'b0, 3'd0, P0,       1'b0, 3'd0, P1,       3'd0);

    rst_n = 1'b0;
    drive(mk(1'b0, 5'd0, 32'h0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 3'd0, P0, 1'b0, 3'd0, P1, 3'd0));
    #12;
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      exp_q.push_back(to_exp(tbl[i]));
      @(negedge clk);
      check_out(i);
    end

    // Fill all four entries, then pull reset between edges.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      drive(mk(1'b1, 5'(11 + i), 32'(32'hC0 + i), 1'b0, 2'b11, 5'd0, 5'd0,
               1'b0, 3'd0, P0, 1'b0, 3'd0, P1, 3'd0));
    end
    @(posedge clk);
    #1;
    v = mk(1'b0, 5'd0, 32'h0, 1'b0, 2'b11, 5'd14, 5'd11, 1'b1, 3'd1, 32'hC3, 1'b1, 3'd4, 32'hC0, 3'd4);
    drive(v);
    exp_q.push_back(to_exp(v));
    #2;
    check_out(100);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(to_exp(mk(1'b0, 5'd0, 32'h0, 1'b0, 2'b11, 5'd14, 5'd11,
                              1'b0, 3'd0, P0, 1'b0, 3'd0, P1, 3'd0)));
    check_out(101);
    v = mk(1'b1, 5'd2, 32'h77, 1'b0, 2'b11, 5'd2, 5'd3, 1'b1, 3'd0, 32'h77, 1'b0, 3'd0, P1, 3'd0);
    drive(v);
    exp_q.push_back(to_exp(v));
    #1;
    check_out(102);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/forward_wb_history.md
Name: forward_wb_history

Overview:
- Parametrised successor to the single-port WB->MEM rs2 bypass.
- Holds the last DEPTH register-file writebacks in a small history buffer, so a stage stalled behind a retired producer still gets the correct operand after that producer has left WB.
- Serves NPORTS consumer operand ports at once, with newest-wins priority, x0 suppression, per-port enable and pipeline flush.
- Sits beside the regfile, between WB and the MEM/EX operand muxes.

Parameters:
- XLEN, 32, data width (rv32i_word).
- REG_W, 5, register-number width (rv32i_reg).
- DEPTH, 4, number of history entries (>=1).
- NPORTS, 2, number of consumer operand ports (>=1).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_load_regfile  in  1  WB instruction writes the regfile this cycle (WB control word load_regfile AND WB valid).
- wb_rd_num  in  REG_W  WB destination register.
- wb_rd_data  in  XLEN  WB write data.
- flush  in  1  pipeline flush; clears history.
- use_fwd  in  NPORTS  per-port forwarding enable (0 for ports whose operand is unused, e.g. rs2 of op_imm).
- src_num  in  NPORTS*REG_W  per-port source register number; port p = bits [p*REG_W +: REG_W].
- src_data  in  NPORTS*XLEN  per-port regfile data before forwarding.
- fwd_data  out  NPORTS*XLEN  per-port data after forwarding.
- fwd_hit  out  NPORTS  port p was forwarded.
- fwd_src  out  NPORTS*CNT_W  per-port source: 0 = live WB, k = history entry k-1; 0 when no hit.
- hist_count  out  CNT_W  number of valid history entries.

Behaviour:
- State: entries h[0..DEPTH-1], each {valid, rd, data}; h[0] is newest.
- Reset (rst_n=0, asynchronous): all valid = 0, rd = 0, data = 0, so hist_count = 0.
- Outputs during reset are purely combinational from live WB: fwd_hit = 0 except for live-WB matches; fwd_data = src_data otherwise.
- Push condition: wb_load_regfile=1 AND wb_rd_num != 0. On the next edge:
  - h[0] <= {1, wb_rd_num, wb_rd_data}.
  - h[i] <= h[i-1] for i >= 1; the old h[DEPTH-1] is dropped.
- De-duplication: when pushing rd X, every shifted entry with rd == X gets valid cleared in the same edge. At most one valid entry per register.
- No push: entries hold.
- flush=1: all valid bits cleared on the edge. If a push happens in the same cycle, the push is still recorded, so after the edge only h[0] is valid (hist_count = 1). WB is older than any flushed instruction.
- hist_count = popcount of the valid bits; registered, consistent with the entries after each edge; never exceeds DEPTH.
- Lookup is combinational, independently per port p:
  - Hit on live WB: use_fwd[p] AND src_num[p] != 0 AND wb_load_regfile AND wb_rd_num == src_num[p]. This has highest priority.
  - Otherwise hit on the lowest index k with h[k].valid AND h[k].rd == src_num[p]; fwd_src = k+1.
  - A miss, use_fwd[p]=0, or src_num[p]=0 gives fwd_data = src_data[p], fwd_hit = 0, fwd_src = 0.
- Latency: a value written in WB at cycle t is forwardable combinationally in cycle t (live path) and from history in cycles t+1 onward, until it is evicted, overwritten by a newer write to the same rd, or flushed.
- A later write to the same register always wins, whether in live WB or a newer entry.
- Ports are independent; two ports reading the same register get identical results.
- No internal path from outputs to state (no combinational loop); the buffer does not gate its push on consumer activity.

Test Plan:
- Reset then rst_n=1: WB x5=0x11 with port0 src=5, use=1 -> same cycle fwd_data0=0x11, hit=1, src=0. Next cycle (no WB) -> fwd_data0=0x11, src=1, hist_count=1.
- DEPTH=4: push x1..x5 with data 0xA1..0xA5 on consecutive cycles -> x1 misses (returns src_data), x5 src=1, x2 src=4, hist_count=4.
- Push x3=0x10, then x7=0x20, then x3=0x30 -> x3 returns 0x30 with src=1, the old x3 entry is invalid, hist_count=2. Live WB x3=0x40 in the same cycle -> 0x40, src=0.
- x0 and enable: WB writes x0=0xFFFF -> no push, a port with src=0 gets src_data. use_fwd=0 with src=5 after x5 was pushed -> passthrough, hit=0.
- Flush: 3 valid entries, flush together with a push of x9=0x99 -> after the edge hist_count=1, only x9 hits. Flush alone -> hist_count=0.
- Async reset mid-operation: assert rst_n=0 between edges with 4 valid entries -> hist_count=0 and all history hits cleared immediately, without waiting for a clock edge.
